// File: rtl/evm_pkg.sv
// Shared definitions for the ballot-side front end of the voting machine.
//   vote_state_t : ballot FSM states
//   *_DEF        : default values for the vote_pulse_gen parameters
package evm_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    DEBOUNCE = 3'd2,
    PULSE    = 3'd3,
    LOCKOUT  = 3'd4
  } vote_state_t;

  localparam int NUM_CAND_DEF        = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int LOCKOUT_CYCLES_DEF  = 8;

endpackage

// File: rtl/vote_pulse_gen_btn_sync.sv
// Two-flop synchronizer, parameterised width, asynchronous active-high reset.
//   i_clk   : destination clock
//   i_rst   : asynchronous reset, clears both flop stages
//   i_async : asynchronous input bus
//   o_sync  : synchronized copy, two destination edges behind i_async
module btn_sync #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/vote_pulse_gen.sv
// Ballot-side front end: turns raw candidate buttons into one single-cycle
// count_in pulse per authorised voter, with debounce, multi-press rejection
// and post-vote lockout.
//   clk          : system clock, rising edge
//   resetCounter : asynchronous active-high reset (shared with the counters)
//   enable_vote  : officer arm control, only its rising edge arms the ballot
//   btn_in       : raw asynchronous candidate buttons, active-high
//   count_in     : one-hot single-cycle vote pulse to the candidate counters
//   ready        : ballot armed (ARMED or DEBOUNCE)
//   busy         : FSM not in IDLE
//   invalid      : registered, more than one button held while armed
//   vote_done    : single-cycle pulse coincident with count_in
module vote_pulse_gen
  import evm_pkg::*;
#(
  parameter int NUM_CAND        = NUM_CAND_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                resetCounter,
  input  logic                enable_vote,
  input  logic [NUM_CAND-1:0] btn_in,
  output logic [NUM_CAND-1:0] count_in,
  output logic                ready,
  output logic                busy,
  output logic                invalid,
  output logic                vote_done
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_ONE  = DEB_W'(1);
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [LOCK_W-1:0] LOCK_ONE = LOCK_W'(1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCKOUT_CYCLES);

  logic [NUM_CAND-1:0] w_btn_sync;
  logic                w_any;
  logic                w_multi;
  logic                w_onehot;
  logic                w_arm;

  logic                r_en_q;
  vote_state_t         r_state;
  vote_state_t         w_state_n;
  logic [NUM_CAND-1:0] r_cand;
  logic [NUM_CAND-1:0] w_cand_n;
  logic [DEB_W-1:0]    r_deb_cnt;
  logic [DEB_W-1:0]    w_deb_cnt_n;
  logic [LOCK_W-1:0]   r_lock_cnt;
  logic [LOCK_W-1:0]   w_lock_cnt_n;
  logic                r_invalid;

  btn_sync #(
    .WIDTH (NUM_CAND)
  ) u_btn_sync (
    .i_clk   (clk),
    .i_rst   (resetCounter),
    .i_async (btn_in),
    .o_sync  (w_btn_sync)
  );

  // x & (x-1) clears the lowest set bit, so anything left means 2+ buttons.
  assign w_any    = |w_btn_sync;
  assign w_multi  = |(w_btn_sync & (w_btn_sync - NUM_CAND'(1)));
  assign w_onehot = w_any & ~w_multi;

  // Only a fresh rising edge of enable_vote arms; holding it high does not.
  assign w_arm = enable_vote & ~r_en_q;

  always_ff @(posedge clk or posedge resetCounter) begin
    if (resetCounter) begin
      r_en_q     <= 1'b0;
      r_state    <= IDLE;
      r_cand     <= '0;
      r_deb_cnt  <= '0;
      r_lock_cnt <= '0;
      r_invalid  <= 1'b0;
    end else begin
      r_en_q     <= enable_vote;
      r_state    <= w_state_n;
      r_cand     <= w_cand_n;
      r_deb_cnt  <= w_deb_cnt_n;
      r_lock_cnt <= w_lock_cnt_n;
      r_invalid  <= (r_state == ARMED) && w_multi;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_cand_n     = r_cand;
    w_deb_cnt_n  = r_deb_cnt;
    w_lock_cnt_n = r_lock_cnt;
    case (r_state)
      IDLE: begin
        // An arm with a button already held is dropped, not deferred.
        if (w_arm && !w_any) begin
          w_state_n = ARMED;
        end
      end
      ARMED: begin
        if (w_onehot) begin
          w_cand_n    = w_btn_sync;
          w_deb_cnt_n = DEB_ONE;
          w_state_n   = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (w_btn_sync == r_cand) begin
          if (r_deb_cnt == DEB_LAST) begin
            w_state_n = PULSE;
          end else if (r_deb_cnt != DEB_MAX) begin
            w_deb_cnt_n = r_deb_cnt + DEB_ONE;
          end
        end else begin
          // Release, change or extra button: restart without voting.
          w_deb_cnt_n = '0;
          w_state_n   = ARMED;
        end
      end
      PULSE: begin
        w_lock_cnt_n = '0;
        w_state_n    = LOCKOUT;
      end
      LOCKOUT: begin
        if (r_lock_cnt != LOCK_MAX) begin
          w_lock_cnt_n = r_lock_cnt + LOCK_ONE;
        end else if (!w_any) begin
          w_state_n = IDLE;
        end
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  // Outputs decode the state register only, so reset clears count_in
  // asynchronously and no input reaches an output combinationally.
  assign count_in  = (r_state == PULSE) ? r_cand : '0;
  assign vote_done = (r_state == PULSE);
  assign ready     = (r_state == ARMED) || (r_state == DEBOUNCE);
  assign busy      = (r_state != IDLE);
  assign invalid   = r_invalid;

endmodule

// File: tb/tb_vote_pulse_gen.sv
module tb_vote_pulse_gen;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         resetCounter;
  logic         enable_vote;
  logic [N-1:0] btn_in;
  logic [N-1:0] count_in;
  logic         ready;
  logic         busy;
  logic         invalid;
  logic         vote_done;

  int errors = 0;
  int checks = 0;
  int pulses [N];

  always #5 clk = ~clk;

  vote_pulse_gen #(
    .NUM_CAND        (N),
    .DEBOUNCE_CYCLES (4),
    .LOCKOUT_CYCLES  (8)
  ) dut (
    .clk          (clk),
    .resetCounter (resetCounter),
    .enable_vote  (enable_vote),
    .btn_in       (btn_in),
    .count_in     (count_in),
    .ready        (ready),
    .busy         (busy),
    .invalid      (invalid),
    .vote_done    (vote_done)
  );

  // Per-candidate up-counter model fed by count_in.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (count_in[i]) pulses[i]++;
    end
  end

  typedef struct {
    logic         en;
    logic [N-1:0] btn;
    logic [7:0]   exp;   // {count_in, vote_done, ready, busy, invalid}
  } vec_t;

  vec_t tbl [20];

  localparam logic [7:0] O_ARM  = 8'b0000_0110;
  localparam logic [7:0] O_LOCK = 8'b0000_0010;
  localparam logic [7:0] O_P2   = 8'b0100_1010;
  localparam logic [7:0] O_ZERO = 8'b0000_0000;

  function automatic logic [7:0] outs();
    return {count_in, vote_done, ready, busy, invalid};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [N-1:0] b, input int n);
    btn_in = b;
    repeat (n) tick();
  endtask

  task automatic arm();
    enable_vote = 1'b0;
    tick();
    enable_vote = 1'b1;
    tick();
    tick();
    check("arm_ready", {31'd0, ready}, 32'd1);
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;

    // Reset with a button held: everything quiet.
    resetCounter = 1'b1;
    enable_vote  = 1'b0;
    btn_in       = 4'b0010;
    tick();
    tick();
    check("reset_outs", {24'd0, outs()}, 32'd0);
    check("reset_no_pulse", pulses[1], 0);
    resetCounter = 1'b0;
    btn_in       = '0;
    repeat (3) tick();
    check("post_reset_idle", {24'd0, outs()}, 32'd0);

    // Normal vote on candidate 2, enable held high from here on.
    tbl[0] = '{1'b1, 4'b0000, O_ARM};
    for (int i = 1; i <= 5; i++) tbl[i] = '{1'b1, 4'b0100, O_ARM};
    tbl[6] = '{1'b1, 4'b0100, O_P2};
    for (int i = 7; i <= 15; i++) tbl[i] = '{1'b1, 4'b0000, O_LOCK};
    tbl[16] = '{1'b1, 4'b0000, O_ZERO};
    tbl[17] = '{1'b1, 4'b0010, O_ZERO};
    tbl[18] = '{1'b1, 4'b0010, O_ZERO};
    tbl[19] = '{1'b1, 4'b0000, O_ZERO};
    for (int i = 0; i < 20; i++) begin
      enable_vote = tbl[i].en;
      btn_in      = tbl[i].btn;
      tick();
      check($sformatf("vec%0d", i), {24'd0, outs()}, {24'd0, tbl[i].exp});
    end
    check("normal_cnt2", pulses[2], 1);
    check("held_enable_cnt1", pulses[1], 0);

    // Third press with enable still high: no re-arm.
    hold(4'b0001, 6);
    hold(4'b0000, 3);
    check("no_rearm_busy", {31'd0, busy}, 32'd0);
    check("no_rearm_cnt0", pulses[0], 0);

    // Bounce 1-2-1-3 then a stable hold.
    arm();
    hold(4'b0001, 1);
    hold(4'b0000, 2);
    hold(4'b0001, 1);
    hold(4'b0000, 3);
    check("bounce_no_pulse", pulses[0], 0);
    check("bounce_still_ready", {31'd0, ready}, 32'd1);
    hold(4'b0001, 5);
    btn_in = '0;
    wait_idle("bounce_idle", 40);
    check("bounce_cnt0", pulses[0], 1);

    // Multi-press rejected, then a clean single press.
    arm();
    hold(4'b0011, 10);
    check("multi_invalid", {31'd0, invalid}, 32'd1);
    check("multi_ready", {31'd0, ready}, 32'd1);
    check("multi_no_pulse", pulses[0] + pulses[1], 1);
    hold(4'b0000, 3);
    check("multi_release_valid", {31'd0, invalid}, 32'd0);
    hold(4'b1000, 5);
    btn_in = '0;
    wait_idle("multi_idle", 40);
    check("multi_cnt3", pulses[3], 1);

    // Reset during DEBOUNCE aborts the vote.
    arm();
    hold(4'b0100, 3);
    check("deb_busy_ready", {30'd0, busy, ready}, 32'd3);
    resetCounter = 1'b1;
    #1;
    check("deb_abort_outs", {24'd0, outs()}, 32'd0);
    enable_vote = 1'b0;
    tick();
    tick();
    resetCounter = 1'b0;
    repeat (8) tick();
    check("deb_abort_cnt2", pulses[2], 1);
    check("deb_abort_busy", {31'd0, busy}, 32'd0);
    hold(4'b0000, 2);

    // Reset during PULSE drops count_in at once.
    arm();
    btn_in = 4'b0001;
    n = 0;
    while (!vote_done && n < 12) begin
      tick();
      n++;
    end
    check("pulse_seen", {28'd0, count_in}, 32'd1);
    resetCounter = 1'b1;
    #1;
    check("pulse_abort_count", {28'd0, count_in}, 32'd0);
    check("pulse_abort_done", {31'd0, vote_done}, 32'd0);
    enable_vote = 1'b0;
    btn_in      = '0;
    tick();
    resetCounter = 1'b0;
    repeat (4) tick();
    check("pulse_abort_cnt0", pulses[0], 1);

    // Button held through lockout keeps busy until release.
    arm();
    hold(4'b0001, 20);
    check("hold_cnt0", pulses[0], 2);
    check("hold_busy", {31'd0, busy}, 32'd1);
    btn_in = '0;
    tick();
    tick();
    check("hold_release_busy", {31'd0, busy}, 32'd1);
    tick();
    check("hold_release_idle", {31'd0, busy}, 32'd0);
    check("total_votes", pulses[0] + pulses[1] + pulses[2] + pulses[3], 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
